// File: rtl/cpu_pkg.sv
// Shared register-read definitions: widths, output-slot state, issue payload
// and the operand select rule (hard zero, then write-back forward, then regfile).
package cpu_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;
  localparam int CNT_W    = 16;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  typedef struct packed {
    data_t     op_a;
    data_t     op_b;
    reg_addr_t rd;
    logic      rd_we;
  } issue_t;

  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == reg_addr_t'(ZERO_REG);
  endfunction

  function automatic logic wb_hits(input logic wb_vld, input reg_addr_t wb_addr,
                                   input reg_addr_t addr);
    return wb_vld && (wb_addr == addr) && !is_zero_reg(addr);
  endfunction

  function automatic data_t sel_operand(input reg_addr_t rs, input data_t rf_dat,
                                        input logic wb_vld, input reg_addr_t wb_addr,
                                        input data_t wb_dat);
    if (is_zero_reg(rs)) return '0;
    if (wb_hits(wb_vld, wb_addr, rs)) return wb_dat;
    return rf_dat;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy bit per architectural register; combinational lookups already discount
// a register being written back this cycle. State updates on the next edge.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              wb_vld_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic              set_vld_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic [ADDR_W-1:0] look_a_i,
  input  logic [ADDR_W-1:0] look_b_i,
  input  logic [ADDR_W-1:0] look_d_i,
  output logic              busy_a_o,
  output logic              busy_b_o,
  output logic              busy_d_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Set is applied after clear so a new writer to the retiring register stays pending.
  always_comb begin
    busy_d = busy_q;
    if (wb_vld_i && !is_zero_reg(wb_addr_i)) busy_d[wb_addr_i] = 1'b0;
    if (set_vld_i && !is_zero_reg(set_addr_i)) busy_d[set_addr_i] = 1'b1;
    if (flush_i) busy_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_a_o = busy_q[look_a_i] && !wb_hits(wb_vld_i, wb_addr_i, look_a_i) && !is_zero_reg(look_a_i);
  assign busy_b_o = busy_q[look_b_i] && !wb_hits(wb_vld_i, wb_addr_i, look_b_i) && !is_zero_reg(look_b_i);
  assign busy_d_o = busy_q[look_d_i] && !wb_hits(wb_vld_i, wb_addr_i, look_d_i) && !is_zero_reg(look_d_i);

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: 1-cycle latency into a one-entry output register; in_ready
// drops on RAW/WAW hazards, on flush, or while execute holds a full slot.
module operand_fetch
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rsA,
  input  logic [ADDR_W-1:0] in_rsB,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_rdWe,
  output logic [ADDR_W-1:0] rf_rdAddrA,
  output logic [ADDR_W-1:0] rf_rdAddrB,
  input  logic [DATA_W-1:0] rf_rdDataA,
  input  logic [DATA_W-1:0] rf_rdDataB,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_opA,
  output logic [DATA_W-1:0] out_opB,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_rdWe,
  output logic [CNT_W-1:0]  stall_cycles
);

  slot_e              state_q, state_d;
  issue_t             issue_q, issue_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               busy_a, busy_b, busy_rd;
  logic               hazard, slot_free, accept;

  assign rf_rdAddrA = in_rsA;
  assign rf_rdAddrB = in_rsB;

  reg_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush),
    .wb_vld_i   (wb_valid),
    .wb_addr_i  (wb_addr),
    .set_vld_i  (accept && in_rdWe),
    .set_addr_i (in_rd),
    .look_a_i   (in_rsA),
    .look_b_i   (in_rsB),
    .look_d_i   (in_rd),
    .busy_a_o   (busy_a),
    .busy_b_o   (busy_b),
    .busy_d_o   (busy_rd)
  );

  assign hazard    = busy_a || busy_b || (in_rdWe && busy_rd);
  assign out_valid = (state_q == SLOT_FULL);
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !hazard && !flush;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (flush)          state_d = SLOT_EMPTY;
    else if (accept)    state_d = SLOT_FULL;
    else if (out_ready) state_d = SLOT_EMPTY;
  end

  always_comb begin
    issue_d = issue_q;
    if (accept) begin
      issue_d.op_a  = sel_operand(in_rsA, rf_rdDataA, wb_valid, wb_addr, wb_data);
      issue_d.op_b  = sel_operand(in_rsB, rf_rdDataB, wb_valid, wb_addr, wb_data);
      issue_d.rd    = in_rd;
      issue_d.rd_we = in_rdWe;
    end
  end

  // Counts cycles an instruction is waiting purely on the scoreboard; saturates.
  always_comb begin
    stall_d = stall_q;
    if (in_valid && hazard && !flush && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      issue_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      stall_q <= stall_d;
    end
  end

  assign out_opA      = issue_q.op_a;
  assign out_opB      = issue_q.op_b;
  assign out_rd       = issue_q.rd;
  assign out_rdWe     = issue_q.rd_we;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed stimulus with a queue scoreboard; a negedge monitor pops one expected
// issue per output handshake.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_rdWe;
  logic [4:0]  in_rsA, in_rsB, in_rd, rf_rdAddrA, rf_rdAddrB, wb_addr, out_rd;
  logic [63:0] rf_rdDataA, rf_rdDataB, wb_data, out_opA, out_opB;
  logic        wb_valid, out_valid, out_ready, out_rdWe;
  logic [15:0] stall_cycles;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] rf [32];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign rf_rdDataA = rf[rf_rdAddrA];
  assign rf_rdDataB = rf[rf_rdAddrB];

  operand_fetch dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rsA(in_rsA), .in_rsB(in_rsB), .in_rd(in_rd), .in_rdWe(in_rdWe),
    .rf_rdAddrA(rf_rdAddrA), .rf_rdAddrB(rf_rdAddrB),
    .rf_rdDataA(rf_rdDataA), .rf_rdDataB(rf_rdDataB),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opA(out_opA), .out_opB(out_opB), .out_rd(out_rd), .out_rdWe(out_rdWe),
    .stall_cycles(stall_cycles)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected issue.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out opA=0x%0h rd=%0d at %0t", out_opA, out_rd, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_opA",  out_opA, mon_e.a);
        chk("mon_opB",  out_opB, mon_e.b);
        chk("mon_rd",   64'(out_rd), 64'(mon_e.rd));
        chk("mon_rdWe", 64'(out_rdWe), 64'(mon_e.we));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                      input logic we, input logic [63:0] ea, input logic [63:0] eb,
                      input logic wv, input logic [4:0] wa, input logic [63:0] wd,
                      input int max_wait);
    int waited = 0;
    in_rsA = a; in_rsB = b; in_rd = d; in_rdWe = we; in_valid = 1'b1;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    @(negedge clk);
    while (!in_ready && waited < max_wait) begin
      waited++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    exp_q.push_back('{a: ea, b: eb, rd: d, we: we});
    @(posedge clk); #1;
    in_valid = 1'b0; wb_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'(i) * 64'h10;
    rf[31] = 64'hBAD0_BAD0_BAD0_BAD0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rsA = '0; in_rsB = '0; in_rd = '0;
    in_rdWe = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_opA", out_opA, 64'd0);
    chk("rst_opB", out_opB, 64'd0);
    chk("rst_rd", 64'(out_rd), 64'd0);
    chk("rst_rdWe", 64'(out_rdWe), 64'd0);
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    #11 reset = 1'b0;
    @(posedge clk); #1;

    // Basic issue: X1/X2 from regfile, destination 3 becomes busy.
    send(5'd1, 5'd2, 5'd3, 1'b1, 64'h10, 64'h20, 1'b0, 5'd0, 64'd0, 0);

    // RAW stall on X3 until write-back forwards it.
    in_rsA = 5'd3; in_rsB = 5'd0; in_rd = 5'd8; in_rdWe = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("raw_stall_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    chk("raw_stall_cnt", 64'(stall_cycles), 64'd3);
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 64'hDEAD;
    @(negedge clk);
    chk("raw_fwd_ready", 64'(in_ready), 64'd1);
    exp_q.push_back('{a: 64'hDEAD, b: 64'h0, rd: 5'd8, we: 1'b1});
    @(posedge clk); #1;
    in_valid = 1'b0; wb_valid = 1'b0;
    chk("raw_cnt_hold", 64'(stall_cycles), 64'd3);

    // Hard-zero register: reads 0, never busy, never forwarded.
    send(5'd31, 5'd31, 5'd31, 1'b1, 64'h0, 64'h0, 1'b0, 5'd0, 64'd0, 0);
    send(5'd31, 5'd1, 5'd9, 1'b0, 64'h0, 64'h10, 1'b1, 5'd31, 64'hFFFF, 0);

    // Backpressure: slot full and held for 5 cycles, then same-cycle accept.
    out_ready = 1'b0;
    in_rsA = 5'd1; in_rsB = 5'd2; in_rd = 5'd10; in_rdWe = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_opA", out_opA, 64'h0);
      chk("bp_opB", out_opB, 64'h10);
      chk("bp_rd", 64'(out_rd), 64'd9);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    exp_q.push_back('{a: 64'h10, b: 64'h20, rd: 5'd10, we: 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_stall_cnt", 64'(stall_cycles), 64'd3);

    // Same-cycle clear and set of X5; B operand forwarded.
    send(5'd1, 5'd2, 5'd5, 1'b1, 64'h10, 64'h20, 1'b0, 5'd0, 64'd0, 0);
    send(5'd2, 5'd5, 5'd5, 1'b1, 64'h20, 64'h55, 1'b1, 5'd5, 64'h55, 0);
    in_rsA = 5'd5; in_rsB = 5'd0; in_rd = 5'd0; in_rdWe = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("x5_still_busy", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("x5_stall_cnt", 64'(stall_cycles), 64'd4);

    // Flush clears busy X4/X7 (and X5, X8) and empties the slot, even with wb active.
    send(5'd0, 5'd0, 5'd4, 1'b1, 64'h0, 64'h0, 1'b0, 5'd0, 64'd0, 0);
    send(5'd0, 5'd0, 5'd7, 1'b1, 64'h0, 64'h0, 1'b0, 5'd0, 64'd0, 0);
    flush = 1'b1; wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 64'h5555;
    in_rsA = 5'd4; in_rsB = 5'd7; in_rd = 5'd8; in_rdWe = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("flush_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; wb_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("flush_busy_clear", 64'(in_ready), 64'd1);
    exp_q.push_back('{a: 64'h40, b: 64'h70, rd: 5'd8, we: 1'b1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("flush_stall_cnt", 64'(stall_cycles), 64'd4);

    // Asynchronous reset in the middle of a stall with a held output.
    send(5'd1, 5'd2, 5'd3, 1'b1, 64'h10, 64'h20, 1'b0, 5'd0, 64'd0, 0);
    out_ready = 1'b0;
    in_rsA = 5'd3; in_rsB = 5'd1; in_rd = 5'd10; in_rdWe = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_stall", 64'(stall_cycles), 64'd6);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_opA", out_opA, 64'd0);
    chk("arst_opB", out_opB, 64'd0);
    chk("arst_rd", 64'(out_rd), 64'd0);
    chk("arst_rdWe", 64'(out_rdWe), 64'd0);
    chk("arst_stall", 64'(stall_cycles), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
